tmds_channel_encoder_hdmi: RTL and testbench

Parametrised single-channel TMDS encoder that generalises the DVI 8b/10b channel encoder with HDMI video-period framing. Internal look-ahead delay line lets the block insert the video preamble and leading guard band automatically before each active-video run. It sits between the video timing/RGB source and the 10:1 serializer, one instance per TMDS data channel. Run-time selectable DVI mode (no insertion) keeps backward compatibility.

---
 rtl/tmds_channel_encoder_hdmi_if.sv | 33 +++
 rtl/tmds_channel_encoder_hdmi.sv | 183 ++++++++++++++++++
 tb/tb_tmds_channel_encoder_hdmi.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tmds_channel_encoder_hdmi_if.sv
// Pixel/control bundle into one TMDS channel encoder and its symbol output.
// TMDS_DISP_MON_EN adds the disparity monitor signals.
interface tmds_channel_encoder_hdmi_if;
  logic       hdmi_mode;
  logic [7:0] din;
  logic       c0;
  logic       c1;
  logic       de;
  logic [9:0] dout;
  logic       dout_de;
`ifdef TMDS_DISP_MON_EN
  logic signed [4:0] disp_cnt;
  logic              disp_err;

  modport master (
    output hdmi_mode, din, c0, c1, de,
    input  dout, dout_de, disp_cnt, disp_err
  );
  modport slave (
    input  hdmi_mode, din, c0, c1, de,
    output dout, dout_de, disp_cnt, disp_err
  );
`else
  modport master (
    output hdmi_mode, din, c0, c1, de,
    input  dout, dout_de
  );
  modport slave (
    input  hdmi_mode, din, c0, c1, de,
    output dout, dout_de
  );
`endif
endinterface

// File: rtl/tmds_channel_encoder_hdmi.sv
// TMDS 8b/10b channel encoder with HDMI preamble/guard-band insertion.
// Optional disparity monitor outputs enabled by TMDS_DISP_MON_EN.
module tmds_channel_encoder_hdmi #(
  parameter int CHANNEL      = 0,
  parameter int PREAMBLE_LEN = 8,
  parameter int GUARD_LEN    = 2
) (
  input logic pclk,
  input logic reset,
  tmds_channel_encoder_hdmi_if.slave bus
);

  localparam int D = PREAMBLE_LEN + GUARD_LEN;

  localparam logic [9:0] GUARD_SYM =
    (CHANNEL == 1) ? 10'b0100110011 : 10'b1011001100;

  typedef enum logic [1:0] {
    CLS_CTRL,
    CLS_GUARD,
    CLS_DATA
  } cls_t;

  function automatic logic [3:0] ones8(input logic [7:0] v);
    ones8 = '0;
    for (int i = 0; i < 8; i++)
      ones8 = ones8 + {3'b000, v[i]};
  endfunction

  function automatic logic [9:0] ctrl_tok(input logic [1:0] c);
    unique case (c)
      2'b00:   ctrl_tok = 10'b1101010100;
      2'b01:   ctrl_tok = 10'b0010101011;
      2'b10:   ctrl_tok = 10'b0101010100;
      default: ctrl_tok = 10'b1010101011;
    endcase
  endfunction

  // entry layout {de, c1, c0, din}
  logic [10:0] dl [D];
  logic [10:0] head;

  assign head = dl[D-1];

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < D; i++)
        dl[i] <= '0;
    end else begin
      dl[0] <= {bus.de, bus.c1, bus.c0, bus.din};
      for (int i = 1; i < D; i++)
        dl[i] <= dl[i-1];
    end
  end

  // ahead[k]: de of the entry k slots behind the head; k == D is the live input
  logic [D:1] ahead;
  logic       near;
  logic       far;

  always_comb begin
    ahead = '0;
    for (int k = 1; k < D; k++)
      ahead[k] = dl[D-1-k][10];
    ahead[D] = bus.de;
  end

  always_comb begin
    near = 1'b0;
    far  = 1'b0;
    for (int k = D; k >= 1; k--) begin
      if (ahead[k]) begin
        near = (k <= GUARD_LEN);
        far  = (k > GUARD_LEN);
      end
    end
  end

  logic       is_data;
  logic       is_guard;
  logic       is_pre;
  logic [1:0] pre_c;

  assign is_data  = head[10];
  assign is_guard = !head[10] && bus.hdmi_mode && near;
  assign is_pre   = !head[10] && bus.hdmi_mode && far;
  assign pre_c    = (CHANNEL == 1) ? 2'b01 :
                    (CHANNEL == 2) ? 2'b00 : head[9:8];

  logic [3:0] n1d;
  logic       xnor_path;
  logic [8:0] qm;

  always_comb begin
    n1d       = ones8(head[7:0]);
    xnor_path = (n1d > 4'd4) || (n1d == 4'd4 && !head[0]);
    qm        = '0;
    qm[0]     = head[0];
    for (int i = 1; i < 8; i++)
      qm[i] = xnor_path ? ~(qm[i-1] ^ head[i]) : (qm[i-1] ^ head[i]);
    qm[8]     = ~xnor_path;
  end

  cls_t       s1_cls;
  logic [1:0] s1_c;
  logic [8:0] s1_qm;

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      s1_cls <= CLS_CTRL;
      s1_c   <= 2'b00;
      s1_qm  <= '0;
    end else begin
      s1_qm <= qm;
      s1_c  <= head[9:8];
      unique case (1'b1)
        is_data:  s1_cls <= CLS_DATA;
        is_guard: s1_cls <= CLS_GUARD;
        is_pre: begin
          s1_cls <= CLS_CTRL;
          s1_c   <= pre_c;
        end
        default:  s1_cls <= CLS_CTRL;
      endcase
    end
  end

  logic signed [4:0] cnt;
  logic signed [4:0] diff;
  logic signed [4:0] cnt_nx;
  logic        [3:0] n1q;
  logic        [3:0] n0q;
  logic        [9:0] sym;

  always_comb begin
    n1q  = ones8(s1_qm[7:0]);
    n0q  = 4'd8 - n1q;
    diff = $signed({1'b0, n1q}) - $signed({1'b0, n0q});
    if (cnt == 5'sd0 || n1q == n0q) begin
      sym    = {~s1_qm[8], s1_qm[8],
                s1_qm[8] ? s1_qm[7:0] : ~s1_qm[7:0]};
      cnt_nx = s1_qm[8] ? cnt + diff : cnt - diff;
    end else if ((!cnt[4] && n1q > n0q) || (cnt[4] && n0q > n1q)) begin
      sym    = {1'b1, s1_qm[8], ~s1_qm[7:0]};
      cnt_nx = cnt + (s1_qm[8] ? 5'sd2 : 5'sd0) - diff;
    end else begin
      sym    = {1'b0, s1_qm[8], s1_qm[7:0]};
      cnt_nx = cnt - (s1_qm[8] ? 5'sd0 : 5'sd2) + diff;
    end
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      bus.dout    <= 10'b1101010100;
      bus.dout_de <= 1'b0;
      cnt         <= '0;
    end else begin
      bus.dout_de <= 1'b0;
      cnt         <= '0;
      unique case (s1_cls)
        CLS_DATA: begin
          bus.dout    <= sym;
          bus.dout_de <= 1'b1;
          cnt         <= cnt_nx;
        end
        CLS_GUARD: bus.dout <= GUARD_SYM;
        default:   bus.dout <= ctrl_tok(s1_c);
      endcase
    end
  end

`ifdef TMDS_DISP_MON_EN
  assign bus.disp_cnt = cnt;

  always_ff @(posedge pclk or posedge reset) begin
    if (reset)
      bus.disp_err <= 1'b0;
    else if (s1_cls == CLS_DATA && (cnt_nx > 5'sd10 || cnt_nx < -5'sd10))
      bus.disp_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_tmds_channel_encoder_hdmi.sv
// Bench for tmds_channel_encoder_hdmi: three channels fed one stream,
// each compared against a slot-level reference model every cycle.
module tb_tmds_channel_encoder_hdmi;

  localparam int P = 8;
  localparam int G = 2;
  localparam int D = P + G;
  localparam int L = D + 2;
  localparam int N = 8192;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hdmi = 1'b0;
  logic       de = 1'b0;
  logic       c0 = 1'b0;
  logic       c1 = 1'b0;
  logic [7:0] din = 8'h00;

  always #5 clk = ~clk;

  tmds_channel_encoder_hdmi_if bus0 ();
  tmds_channel_encoder_hdmi_if bus1 ();
  tmds_channel_encoder_hdmi_if bus2 ();

  assign {bus0.hdmi_mode, bus0.de, bus0.c1, bus0.c0, bus0.din} = {hdmi, de, c1, c0, din};
  assign {bus1.hdmi_mode, bus1.de, bus1.c1, bus1.c0, bus1.din} = {hdmi, de, c1, c0, din};
  assign {bus2.hdmi_mode, bus2.de, bus2.c1, bus2.c0, bus2.din} = {hdmi, de, c1, c0, din};

  tmds_channel_encoder_hdmi #(.CHANNEL(0), .PREAMBLE_LEN(P), .GUARD_LEN(G))
    dut0 (.pclk(clk), .reset(rst), .bus(bus0));
  tmds_channel_encoder_hdmi #(.CHANNEL(1), .PREAMBLE_LEN(P), .GUARD_LEN(G))
    dut1 (.pclk(clk), .reset(rst), .bus(bus1));
  tmds_channel_encoder_hdmi #(.CHANNEL(2), .PREAMBLE_LEN(P), .GUARD_LEN(G))
    dut2 (.pclk(clk), .reset(rst), .bus(bus2));

  logic [9:0] qd  [3];
  logic       qde [3];
  assign qd[0] = bus0.dout;  assign qde[0] = bus0.dout_de;
  assign qd[1] = bus1.dout;  assign qde[1] = bus1.dout_de;
  assign qd[2] = bus2.dout;  assign qde[2] = bus2.dout_de;

`ifdef TMDS_DISP_MON_EN
  logic [4:0] qc [3];
  logic       qe [3];
  assign qc[0] = bus0.disp_cnt;  assign qe[0] = bus0.disp_err;
  assign qc[1] = bus1.disp_cnt;  assign qe[1] = bus1.disp_err;
  assign qc[2] = bus2.disp_cnt;  assign qe[2] = bus2.disp_err;
`endif

  logic [9:0] tok [4] = '{10'b1101010100, 10'b0010101011,
                          10'b0101010100, 10'b1010101011};

  logic [10:0] ent    [N];
  bit          rst_at [N];
  bit          hdm_at [N];
  int n        = 0;
  int last_rst = 0;
  int mcnt     = 0;
  int checks   = 0;
  int errors   = 0;

  task automatic cmp(input string nm, input int ch,
                     input logic [9:0] got, input logic [9:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s ch%0d step %0d got %b exp %b", nm, ch, n, got, exp);
    end
  endtask

  task automatic lit(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", nm, got, exp);
    end
  endtask

  // DVI 8b/10b; running disparity taken as ones minus zeros of each symbol
  function automatic void enc(input logic [7:0] d, input int ci,
                              output logic [9:0] s, output int co);
    logic [8:0] q;
    bit x, inv;
    int a, b;
    x = ($countones(d) > 4) || ($countones(d) == 4 && d[0] == 1'b0);
    q[0] = d[0];
    for (int i = 1; i < 8; i++)
      q[i] = x ? (q[i-1] ~^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = !x;
    a = $countones(q[7:0]);
    b = 8 - a;
    if (ci == 0 || a == b) inv = !q[8];
    else if ((ci > 0 && a > b) || (ci < 0 && b > a)) inv = 1'b1;
    else inv = 1'b0;
    s  = {inv, q[8], inv ? ~q[7:0] : q[7:0]};
    co = ci + 2 * $countones(s) - 10;
  endfunction

  function automatic logic [10:0] ent_at(input int i);
    if (i < 1 || i <= last_rst) return 11'h000;
    return ent[i];
  endfunction

  task automatic check_out();
    logic [9:0]  exp [3];
    logic        exp_de;
    logic [10:0] h, t;
    logic [9:0]  s;
    logic [1:0]  pc;
    int m, e, f, nc;
    m = n;
    exp_de = 1'b0;
    if (rst_at[m] || rst_at[m-1]) begin
      for (int ch = 0; ch < 3; ch++) exp[ch] = tok[0];
      mcnt = 0;
    end else begin
      e = m - L + 1;
      h = ent_at(e);
      if (h[10]) begin
        enc(h[7:0], mcnt, s, nc);
        for (int ch = 0; ch < 3; ch++) exp[ch] = s;
        exp_de = 1'b1;
        mcnt = nc;
      end else begin
        mcnt = 0;
        f = 0;
        for (int k = D; k >= 1; k--) begin
          t = ent_at(e + k);
          if (t[10]) f = k;
        end
        for (int ch = 0; ch < 3; ch++) begin
          pc = (ch == 1) ? 2'b01 : (ch == 2) ? 2'b00 : h[9:8];
          if (hdm_at[m-1] && f >= 1 && f <= G)
            exp[ch] = (ch == 1) ? 10'b0100110011 : 10'b1011001100;
          else if (hdm_at[m-1] && f > G)
            exp[ch] = tok[pc];
          else
            exp[ch] = tok[h[9:8]];
        end
      end
    end
    for (int ch = 0; ch < 3; ch++) begin
      cmp("dout", ch, qd[ch], exp[ch]);
      cmp("dout_de", ch, {9'b0, qde[ch]}, {9'b0, exp_de});
`ifdef TMDS_DISP_MON_EN
      cmp("disp_cnt", ch, {5'b0, qc[ch]}, {5'b0, mcnt[4:0]});
      cmp("disp_err", ch, {9'b0, qe[ch]}, 10'b0);
`endif
    end
  endtask

  task automatic step();
    @(posedge clk);
    n++;
    if (n >= N) begin
      $display("FAIL step_budget got %0d limit %0d", n, N);
      $fatal(1, "step budget exceeded");
    end
    rst_at[n] = rst;
    hdm_at[n] = hdmi;
    ent[n]    = rst ? 11'h000 : {de, c1, c0, din};
    if (rst) last_rst = n;
    #1;
    check_out();
  endtask

  logic [9:0] ms;
  int mc, cnt_a, cnt_b, gap, run;

  initial begin
    rst_at[0] = 1'b1;
    enc(8'h00, 0, ms, mc);
    lit("model_00_sym", int'(ms), int'(10'b0100000000));
    lit("model_00_cnt", mc, -8);
    enc(8'hFF, 0, ms, mc);
    lit("model_ff_sym", int'(ms), int'(10'b1000000000));
    lit("model_ff_cnt", mc, -8);
    enc(8'h00, -8, ms, mc);
    lit("model_00n_sym", int'(ms), int'(10'b1111111111));
    lit("model_00n_cnt", mc, 2);

    repeat (3) step();
    for (int ch = 0; ch < 3; ch++) begin
      lit("reset_dout", int'(qd[ch]), int'(10'b1101010100));
      lit("reset_de", int'(qde[ch]), 0);
    end

    rst = 1'b0; hdmi = 1'b0; de = 1'b1; din = 8'h00;
    repeat (L) step();
    lit("dvi_first_data", int'(qd[0]), int'(10'b0100000000));
    step();
    lit("dvi_second_data", int'(qd[0]), int'(10'b1111111111));
    repeat (4) step();

    de = 1'b0;
    for (int i = 0; i < 16; i++) begin
      {c1, c0} = i[1:0];
      step();
    end
    {c1, c0} = 2'b00;
    repeat (L) step();

    hdmi = 1'b1; cnt_a = 0; cnt_b = 0;
    for (int i = 1; i <= 40; i++) begin
      de = (i > 20); {c1, c0} = 2'b00; din = 8'($urandom);
      step();
      if (i <= 32 && qd[1] == 10'b0100110011) cnt_a++;
      if (i <= 32 && qd[1] == 10'b0010101011) cnt_b++;
      if (i == 32) lit("ch1_first_data_de", int'(qde[1]), 1);
    end
    lit("ch1_guard_count", cnt_a, 2);
    lit("ch1_preamble_count", cnt_b, 8);

    for (int i = 1; i <= 40; i++) begin
      de = (i > 20); {c1, c0} = 2'b10; din = 8'($urandom);
      step();
    end

    {c1, c0} = 2'b00; cnt_a = 0; cnt_b = 0;
    for (int i = 1; i <= 40; i++) begin
      de = !(i >= 13 && i <= 16); din = 8'($urandom);
      step();
      if (qd[2] == 10'b1011001100) cnt_a++;
      if (!qde[2]) cnt_b++;
    end
    lit("ch2_short_guard_count", cnt_a, 2);
    lit("ch2_short_blank_slots", cnt_b, 4);

    for (int sg = 0; sg < 80; sg++) begin
      gap = int'($urandom_range(1, 24));
      run = int'($urandom_range(1, 30));
      hdmi = ($urandom_range(0, 3) != 0);
      {c1, c0} = 2'($urandom);
      for (int i = 0; i < gap; i++) begin
        de = 1'b0; din = 8'($urandom);
        if ($urandom_range(0, 15) == 0) hdmi = !hdmi;
        if ($urandom_range(0, 3) == 0) {c1, c0} = 2'($urandom);
        step();
      end
      for (int i = 0; i < run; i++) begin
        de = 1'b1; din = 8'($urandom);
        step();
      end
    end

    hdmi = 1'b0; de = 1'b1;
    for (int i = 0; i < L + 6; i++) begin
      din = (i % 2 == 0) ? 8'h00 : 8'($urandom);
      step();
    end
    #3 rst = 1'b1;
    #1;
    for (int ch = 0; ch < 3; ch++) begin
      lit("async_reset_dout", int'(qd[ch]), int'(10'b1101010100));
      lit("async_reset_de", int'(qde[ch]), 0);
    end
    repeat (2) step();
    rst = 1'b0; cnt_a = 0;
    for (int i = 1; i < L; i++) begin
      din = 8'($urandom);
      step();
      for (int ch = 0; ch < 3; ch++)
        if (qd[ch] == 10'b1101010100 && !qde[ch]) cnt_a++;
    end
    lit("post_reset_ctrl_slots", cnt_a, 3 * (L - 1));
    repeat (L + 4) begin
      din = 8'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
